// File: rtl/cell_pos_rd_ctrl.sv
// Position-cell RAM access controller: reads the particle count at address 0, then streams
// positions 1..N through a 4-entry credit-controlled buffer; grants writes only while idle.
module cell_pos_rd_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] cnt_out,
  output logic                  cnt_err,
  output logic [DATA_WIDTH-1:0] pos_out,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic                  pos_last,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH-1:0] MaxCnt = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {StIdle, StRdCnt, StWaitCnt, StStream, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, idx_q, n_q, cnt_q;
  logic                  rden_q, rlast_q, p1_q, p1_last_q, p2_q, p2_last_q;
  logic                  rd_done_q, cnt_err_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [4];
  logic [3:0]            fifo_last_q;
  logic [1:0]            wptr_q, rptr_q;
  logic [2:0]            fcnt_q;

  logic                  push, pop, issue_ok, cnt_over;
  logic [3:0]            outstanding;
  logic [ADDR_WIDTH-1:0] raw_cnt, n_new;

  assign push      = p2_q && (state_q == StStream || state_q == StDrain);
  assign pos_valid = (fcnt_q != 3'd0);
  assign pos_out   = fifo_data_q[rptr_q];
  assign pos_last  = pos_valid && fifo_last_q[rptr_q];
  assign pop       = pos_valid && pos_ready;

  // Reads in the pipe plus buffered words after this edge must never exceed the buffer depth.
  assign outstanding = 4'(fcnt_q) + 4'(p2_q) + 4'(p1_q) + 4'(rden_q) - 4'(pop);
  assign issue_ok    = (outstanding < 4'd4);

  assign raw_cnt  = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over = (raw_cnt > MaxCnt);
  assign n_new    = cnt_over ? MaxCnt : raw_cnt;

  assign rd_busy  = (state_q != StIdle);
  assign rd_done  = rd_done_q;
  assign cnt_out  = cnt_q;
  assign cnt_err  = cnt_err_q;
  assign wr_grant = (state_q == StIdle) && wr_req;
  assign mem_wren = wr_grant;
  assign mem_addr = wr_grant ? wr_addr : addr_q;
  assign mem_data = wr_data;
  assign mem_rden = rden_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      idx_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      rden_q    <= 1'b0;
      rlast_q   <= 1'b0;
      p1_q      <= 1'b0;
      p1_last_q <= 1'b0;
      p2_q      <= 1'b0;
      p2_last_q <= 1'b0;
      rd_done_q <= 1'b0;
      cnt_err_q <= 1'b0;
    end else begin
      rden_q    <= 1'b0;
      rd_done_q <= 1'b0;
      p1_q      <= rden_q;
      p1_last_q <= rlast_q;
      p2_q      <= p1_q;
      p2_last_q <= p1_last_q;
      unique case (state_q)
        StIdle: begin
          if (!wr_req && rd_start) begin
            state_q <= StRdCnt;
            rden_q  <= 1'b1;
            addr_q  <= '0;
            rlast_q <= 1'b0;
          end
        end
        StRdCnt: state_q <= StWaitCnt;
        StWaitCnt: begin
          if (p2_q) begin
            n_q   <= n_new;
            cnt_q <= n_new;
            if (cnt_over) cnt_err_q <= 1'b1;
            if (n_new == '0) begin
              rd_done_q <= 1'b1;
              state_q   <= StDrain;
            end else begin
              // Address 1 is issued straight from here so it lands in the first STREAM cycle.
              rden_q  <= 1'b1;
              addr_q  <= ADDR_WIDTH'(1);
              rlast_q <= (n_new == ADDR_WIDTH'(1));
              idx_q   <= ADDR_WIDTH'(2);
              state_q <= (n_new == ADDR_WIDTH'(1)) ? StDrain : StStream;
            end
          end
        end
        StStream: begin
          if (issue_ok) begin
            rden_q  <= 1'b1;
            addr_q  <= idx_q;
            rlast_q <= (idx_q == n_q);
            idx_q   <= idx_q + ADDR_WIDTH'(1);
            if (idx_q == n_q) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (rd_done_q) state_q <= StIdle;
          else if (pop && pos_last) rd_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      fifo_last_q <= '0;
    end else begin
      if (push) begin
        fifo_last_q[wptr_q] <= p2_last_q;
        wptr_q              <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      fcnt_q <= fcnt_q + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data_q[wptr_q] <= mem_q;
  end

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fcnt_q == 3'd4));
`endif

endmodule

// File: tb/tb_cell_pos_rd_ctrl.sv
// Directed bench for cell_pos_rd_ctrl with a 2-cycle-latency single-port RAM model.
module tb_cell_pos_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start, rd_busy, rd_done, cnt_err, pos_valid, pos_ready, pos_last;
  logic [7:0]  cnt_out, wr_addr, mem_addr;
  logic [95:0] pos_out, wr_data, mem_data, mem_q;
  logic        wr_req, wr_grant, mem_rden, mem_wren;

  logic [95:0] ram [0:219];
  logic [95:0] ram_s1, ram_s2;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cell_pos_rd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .rd_done   (rd_done),
    .cnt_out   (cnt_out),
    .cnt_err   (cnt_err),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .pos_last  (pos_last),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_grant  (wr_grant),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_rden  (mem_rden),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q)
  );

  always @(posedge clk) begin
    if (mem_wren && mem_addr < 8'd220) ram[mem_addr] <= mem_data;
    ram_s1 <= (mem_rden && mem_addr < 8'd220) ? ram[mem_addr] : '0;
    ram_s2 <= ram_s1;
  end
  assign mem_q = ram_s2;

  function automatic logic [95:0] word(input int i);
    return {32'(i) ^ 32'h5a5a_0000, 32'(i * 7), 32'hc0de_0000 | 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [95:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_req = 1'b0;
  endtask

  // Raises rd_start, then accepts words until rd_done, checking order, tagging and credit.
  task automatic run_stream(input int n, input bit toggle);
    int  got, issued, max_out, max_addr;
    bit  done;
    got = 0; issued = 0; max_out = 0; max_addr = 0; done = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("rd_cnt_cycle", {rd_busy, mem_rden, mem_addr}, {1'b1, 1'b1, 8'd0});
    for (int k = 0; k < 3000 && !done; k++) begin
      pos_ready = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      #1;
      if (mem_rden && mem_addr != 8'd0) begin
        issued++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (issued - got > max_out) max_out = issued - got;
      if (rd_done) done = 1'b1;
      else if (pos_valid && pos_ready) begin
        got++;
        chk($sformatf("word%0d", got), pos_out, word(got));
        chk($sformatf("last%0d", got), pos_last, (got == n));
      end
      step();
    end
    chk("stream_done", done, 1'b1);
    chk("word_count", got, n);
    chk("max_outstanding_le4", (max_out <= 4), 1'b1);
    chk("max_read_addr", max_addr, n);
    chk("idle_after_done", rd_busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rd_start = 1'b0; pos_ready = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    chk("rst_ctrl", {rd_busy, rd_done, pos_valid, pos_last, mem_rden, cnt_err},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_cnt_addr", {cnt_out, mem_addr}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Write count 3 and a pattern into every position.
    wr_req = 1'b1; wr_addr = 8'd0; wr_data = 96'd3;
    #1;
    chk("idle_grant", {wr_grant, mem_wren, mem_addr}, {1'b1, 1'b1, 8'd0});
    step();
    wr_req = 1'b0;
    for (int i = 1; i < 220; i++) wr(8'(i), word(i));

    // Write then stream A,B,C with exact cycle timing.
    pos_ready = 1'b1;
    rd_start  = 1'b1;
    step();
    rd_start = 1'b0;
    chk("t1_rdcnt", {rd_busy, mem_rden, mem_addr}, {1'b1, 1'b1, 8'd0});
    repeat (3) step();
    chk("t4_first_read", {mem_rden, mem_addr, cnt_out}, {1'b1, 8'd1, 8'd3});
    repeat (2) step();
    chk("t6_no_valid", pos_valid, 1'b0);
    step();
    chk("t7_A", {pos_valid, pos_last, pos_out}, {1'b1, 1'b0, word(1)});
    step();
    chk("t8_B", {pos_valid, pos_last, pos_out}, {1'b1, 1'b0, word(2)});
    step();
    chk("t9_C", {pos_valid, pos_last, pos_out}, {1'b1, 1'b1, word(3)});
    step();
    chk("t10_done", {rd_done, rd_busy, pos_valid}, {1'b1, 1'b1, 1'b0});
    wr_req = 1'b1; wr_addr = 8'd230; wr_data = '0;
    #1;
    chk("t10_no_grant", wr_grant, 1'b0);
    step();
    chk("t11_idle_grant", {rd_busy, rd_done, wr_grant, mem_wren, mem_addr},
        {1'b0, 1'b0, 1'b1, 1'b1, 8'd230});
    wr_req = 1'b0;

    // Empty cell.
    wr(8'd0, 96'd0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("e1_busy", rd_busy, 1'b1);
    repeat (2) step();
    chk("e3_busy_nodone", {rd_busy, rd_done}, 2'b10);
    step();
    chk("e4_done", {rd_busy, rd_done, pos_valid, cnt_out}, {1'b1, 1'b1, 1'b0, 8'd0});
    step();
    chk("e5_idle", {rd_busy, rd_done, pos_valid}, 3'b000);

    // Backpressure with ready toggling 1-0-0-1.
    wr(8'd0, 96'd10);
    run_stream(10, 1'b1);
    chk("bp_cnt", cnt_out, 8'd10);

    // Clamp of an oversized count.
    wr(8'd0, 96'd250);
    run_stream(219, 1'b0);
    chk("clamp_cnt_err", {cnt_out, cnt_err}, {8'd219, 1'b1});

    // Write and read requested together: write first, read the next cycle.
    wr_req = 1'b1; wr_addr = 8'd0; wr_data = 96'd2; rd_start = 1'b1;
    #1;
    chk("arb_write_first", {wr_grant, mem_wren, rd_busy}, 3'b110);
    step();
    wr_req = 1'b0;
    chk("arb_still_idle", rd_busy, 1'b0);
    run_stream(2, 1'b0);

    // Reset during a stalled stream of 8, with a write attempt held off.
    wr(8'd0, 96'd8);
    pos_ready = 1'b0;
    rd_start  = 1'b1;
    step();
    rd_start = 1'b0;
    wr_req = 1'b1; wr_addr = 8'd5; wr_data = '1;
    #1;
    chk("busy_no_grant", {wr_grant, mem_wren, mem_addr}, {1'b0, 1'b0, 8'd0});
    repeat (7) step();
    chk("stall_valid", {pos_valid, pos_out, wr_grant}, {1'b1, word(1), 1'b0});
    chk("err_sticky", cnt_err, 1'b1);
    wr_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {rd_busy, rd_done, pos_valid, pos_last, mem_rden, cnt_err},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("midrst_cnt_addr", {cnt_out, mem_addr}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", pos_valid, 1'b0);
    run_stream(8, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cell_pos_rd_ctrl.md
# cell_pos_rd_ctrl

Access controller for one position cell memory, the single-port 96-bit RAM with 2-cycle read latency whose address 0 holds the particle count. It sits between that RAM, the force-evaluation pipeline and the motion-update writer. On request it reads the count, then streams positions 1..N to the consumer through a 4-entry credit-controlled output buffer with valid/ready backpressure. Motion-update writes are granted only while the controller is idle.

## Interface
- DATA_WIDTH, 96: position word width, {posz, posy, posx}.
- ADDR_WIDTH, 8: RAM address width.
- PARTICLE_NUM, 220: RAM depth; the largest legal count is PARTICLE_NUM-1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_start  in  1  level request to stream the cell; sampled only in IDLE.
- rd_busy  out  1  high in every state except IDLE.
- rd_done  out  1  one-cycle pulse when the stream completes.
- cnt_out  out  ADDR_WIDTH  particle count after clamping; valid from the first pos_valid (or the rd_done of an empty cell) until the next read starts.
- cnt_err  out  1  sticky; set when the stored count exceeds PARTICLE_NUM-1; cleared by reset only.
- pos_out  out  DATA_WIDTH  head of the output buffer.
- pos_valid  out  1  output buffer not empty.
- pos_ready  in  1  consumer accept; a handshake is pos_valid && pos_ready.
- pos_last  out  1  head entry is particle N.
- wr_req  in  1  write request from motion update.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_grant  out  1  combinational; equals (state==IDLE) && wr_req.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_WIDTH  RAM read data; valid 2 cycles after the cycle its address is driven with mem_rden.

## Operation
- **States:** IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN.
- **IDLE:**
  - If wr_req is high, the write path drives the RAM combinationally: mem_addr=wr_addr, mem_data=wr_data, mem_wren=1. Write has priority over rd_start in the same cycle.
  - Else if rd_start is high, go to RD_CNT.
- **RD_CNT:** drive mem_addr=0 with mem_rden=1 for one cycle, then go to WAIT_CNT.
- **WAIT_CNT:** when mem_q[ADDR_WIDTH-1:0] is valid, capture it as N.
  - If the count exceeds PARTICLE_NUM-1, set N=PARTICLE_NUM-1 and set cnt_err.
  - If N==0, pulse rd_done and go to IDLE; no pos_valid is produced.
  - Otherwise set idx=1 and go to STREAM.
- **STREAM:**
  - Each cycle, issue a read of idx (mem_rden=1, idx++) when inflight+occupancy<4. inflight is the number of reads within the 2-cycle latency; occupancy is the output-buffer fill.
  - After the read of N is issued, go to DRAIN.
  - Read addresses are driven from registers.
- **DRAIN:** wait until the buffer is empty and the handshake on the pos_last entry has completed. The cycle after that handshake, pulse rd_done and go to IDLE.
- **Output buffer:** 4-entry FIFO, written by returned mem_q, popped on handshake; push and pop may occur in the same cycle.
  - The credit rule guarantees no overflow; an overflow is an assertion failure.
  - pos_last is tagged on the entry for address N.
- **Write arbitration:** wr_req outside IDLE is ignored (wr_grant=0). The writer holds its request until granted.
- **Reset (async, rst_n=0):**
  - State goes to IDLE and the FIFO is emptied.
  - The in-flight read pipeline valids are cleared and returning data is discarded.
  - All registered outputs are 0: rd_busy, rd_done, pos_valid, pos_last, mem_rden, cnt_out, cnt_err, and the registered mem_addr.
  - Reset mid-stream leaves no residual pos_valid.

## Timing
- rd_start sampled high in IDLE at edge T gives:
  - RD_CNT during cycle T+1, with mem_addr=0 and mem_rden=1;
  - count captured at the end of T+3;
  - first read (addr 1) in T+4;
  - first pos_valid in T+7.
- With pos_ready held high, the controller sustains one particle per cycle.
- The last handshake in cycle L gives rd_done=1 in L+1, IDLE in L+2, and wr_grant possible from L+2.
- Empty cell: rd_done pulses in cycle T+4.
- pos_ready low stalls issue after 4 outstanding reads/entries. Data is never lost or reordered.

## Test plan
- **Write then stream:** wr_req writes addr 0=3 and addr 1..3=A,B,C. Then rd_start with pos_ready=1 -> pos_out A,B,C on consecutive cycles, pos_valid first at T+7, pos_last on C, rd_done the cycle after C, cnt_out=3.
- **Empty cell:** count=0 -> no pos_valid, rd_done at T+4, rd_busy high T+1..T+4.
- **Backpressure:** N=10, pos_ready toggling 1-0-0-1 -> all 10 words in order, never more than 4 reads outstanding+buffered, no FIFO overflow assertion.
- **Clamp:** addr 0=250 with PARTICLE_NUM=220 -> cnt_out=219, cnt_err=1, 219 words streamed, addresses 1..219 only.
- **Arbitration:** wr_req and rd_start both high in IDLE -> write granted first, read starts the next cycle; wr_req during STREAM -> wr_grant=0, mem_wren=0 until IDLE.
- **Reset mid-stream:** rst_n low during STREAM of N=8 -> all outputs 0 immediately, FIFO empty; after release, rd_start restreams from particle 1.
